// File: rtl/array_rw_pkg.sv
// Shared constants and state encoding for the SRAM requester controller.
// Geometry of the single-port, byte-segment-masked macro behind array_rw_ctrl.
package array_rw_pkg;

  localparam int DEPTH      = 4;
  localparam int ADDR_W     = 2;
  localparam int WIDTH      = 34;
  localparam int MASK_SEG   = 2;
  localparam int SEG_W      = WIDTH / MASK_SEG;
  localparam int RESP_DEPTH = 2;

  // Controller states: zero-fill after reset, then serve requests.
  typedef logic [0:0] state_t;
  localparam state_t INIT = 1'b0;
  localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/array_rw_ctrl_if.sv
// Request/response stream between a pipeline client (master) and the array controller (slave).
interface array_rw_ctrl_if;
  import array_rw_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [MASK_SEG-1:0] req_wmask;
  logic [WIDTH-1:0]    req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [WIDTH-1:0]    resp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/array_rw_resp_fifo.sv
// Small synchronous response FIFO; output is read straight from stored entries (no bypass).
module array_rw_resp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic             full;

  assign full      = (occ_reg == OCC_W'(DEPTH));
  assign out_valid = (occ_reg != '0);
  assign out_data  = mem_reg[rd_ptr_reg];
  assign occ       = occ_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      occ_reg <= occ_reg + 1'b1;
      else if (pop && !push) occ_reg <= occ_reg - 1'b1;
    end
  end

  // Upstream credit accounting must make this unreachable.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (!(push && full && !pop)) else $error("array_rw_resp_fifo overflow");
    end
  end

endmodule

// File: rtl/array_rw_ctrl.sv
// Requester-side controller for a 1-cycle-latency masked SRAM macro: zero-fill after reset,
// then stream requests onto the RW0 pins and collect read data into a credit-guarded FIFO.
module array_rw_ctrl
  import array_rw_pkg::*;
#(
  parameter int DEPTH_P      = DEPTH,
  parameter int RESP_DEPTH_P = RESP_DEPTH
) (
  input  logic                clock,
  input  logic                reset_n,
  array_rw_ctrl_if.slave      bus,
  output logic                init_done,
  output logic                RW0_en,
  output logic                RW0_wmode,
  output logic [ADDR_W-1:0]   RW0_addr,
  output logic [MASK_SEG-1:0] RW0_wmask,
  output logic [WIDTH-1:0]    RW0_wdata,
  input  logic [WIDTH-1:0]    RW0_rdata
);

  localparam int OCC_W = $clog2(RESP_DEPTH_P + 1);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] init_ptr_reg;
  logic [ADDR_W-1:0] init_ptr_next;
  logic              rd_pending_reg;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    credit_use;
  logic              fire;
  logic              rd_fire;
  logic              pop;

  assign pop     = bus.resp_valid && bus.resp_ready;
  assign fire    = bus.req_valid && bus.req_ready;
  assign rd_fire = fire && !bus.req_write;

  // Entries held plus the read in flight, minus the one leaving this cycle; pop is
  // counted so a steady read stream runs at full rate with two FIFO entries.
  assign credit_use    = {1'b0, occ} + (OCC_W + 1)'(rd_pending_reg) - (OCC_W + 1)'(pop);
  assign bus.req_ready = reset_n && (state_reg == RUN) &&
                         (credit_use < (OCC_W + 1)'(RESP_DEPTH_P));
  assign init_done     = (state_reg == RUN);

  always_comb begin
    state_next    = state_reg;
    init_ptr_next = init_ptr_reg;
    if (state_reg == INIT) begin
      if (init_ptr_reg == ADDR_W'(DEPTH_P - 1)) begin
        init_ptr_next = '0;
        state_next    = RUN;
      end else begin
        init_ptr_next = init_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= INIT;
      init_ptr_reg   <= '0;
      rd_pending_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      init_ptr_reg   <= init_ptr_next;
      rd_pending_reg <= rd_fire;
    end
  end

  // Pins idle at zero whenever the macro is not enabled, including while reset is held.
  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    if (reset_n) begin
      if (state_reg == INIT) begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = init_ptr_reg;
        RW0_wmask = '1;
      end else if (fire) begin
        RW0_en    = 1'b1;
        RW0_wmode = bus.req_write;
        RW0_addr  = bus.req_addr;
        RW0_wmask = bus.req_wmask;
        RW0_wdata = bus.req_wdata;
      end
    end
  end

  array_rw_resp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RESP_DEPTH_P)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_pending_reg),
    .push_data (RW0_rdata),
    .pop       (pop),
    .out_valid (bus.resp_valid),
    .out_data  (bus.resp_data),
    .occ       (occ)
  );

endmodule

// File: tb/tb_array_rw_ctrl.sv
// Scoreboard bench for array_rw_ctrl with a behavioural masked SRAM model on the RW0 pins.
module tb_array_rw_ctrl;
  import array_rw_pkg::*;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                init_done;
  logic                RW0_en;
  logic                RW0_wmode;
  logic [ADDR_W-1:0]   RW0_addr;
  logic [MASK_SEG-1:0] RW0_wmask;
  logic [WIDTH-1:0]    RW0_wdata;
  logic [WIDTH-1:0]    RW0_rdata = '0;

  array_rw_ctrl_if bus ();

  array_rw_ctrl dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .init_done (init_done),
    .RW0_en    (RW0_en),
    .RW0_wmode (RW0_wmode),
    .RW0_addr  (RW0_addr),
    .RW0_wmask (RW0_wmask),
    .RW0_wdata (RW0_wdata),
    .RW0_rdata (RW0_rdata)
  );

  always #5 clock = ~clock;

  // Macro model: no reset, garbage at start so the zero-fill is observable.
  logic [WIDTH-1:0] mem_m [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem_m[i] = 34'h2_5A5A_A5A5 ^ WIDTH'(i);

  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int s = 0; s < MASK_SEG; s++)
          if (RW0_wmask[s]) mem_m[RW0_addr][s*SEG_W +: SEG_W] <= RW0_wdata[s*SEG_W +: SEG_W];
      end else begin
        RW0_rdata <= mem_m[RW0_addr];
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every accepted response is checked against the oldest expected value.
  always @(negedge clock) begin
    if (reset_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(bus.resp_data), 64'hDEAD);
      end else begin
        chk("resp_data", 64'(bus.resp_data), 64'(exp_q[0]));
        $display("resp data=%h exp=%h", bus.resp_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // Issue one request; returns at posedge+1 after acceptance with req_valid still high.
  task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [MASK_SEG-1:0] m,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_rd, output int waits);
    logic fired;
    fired = 1'b0;
    waits = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wmask = m;
    bus.req_wdata = d;
    for (int n = 0; n < 20 && !fired; n++) begin
      @(negedge clock);
      if (bus.req_ready) begin
        fired = 1'b1;
        chk("rw0_en", 64'(RW0_en), 64'd1);
        chk("rw0_addr", 64'(RW0_addr), 64'(a));
        chk("rw0_wmode", 64'(RW0_wmode), 64'(w));
        if (w) chk("rw0_wdata", 64'(RW0_wdata), 64'(d));
        if (!w) exp_q.push_back(exp_rd);
        $display("req write=%0b addr=%0d mask=%b data=%h waits=%0d", w, a, m, d, waits);
      end else begin
        waits++;
      end
      @(posedge clock); #1;
    end
    if (!fired) chk("req_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_wmask = '0;
    bus.req_wdata = '0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Checks the DEPTH zero-fill writes starting in the current cycle, then init_done.
  task automatic init_seq();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      chk("init_en", 64'(RW0_en), 64'd1);
      chk("init_wmode", 64'(RW0_wmode), 64'd1);
      chk("init_addr", 64'(RW0_addr), 64'(i));
      chk("init_wmask", 64'(RW0_wmask), 64'h3);
      chk("init_wdata", 64'(RW0_wdata), 64'd0);
      chk("init_busy", {62'd0, init_done, bus.req_ready}, 64'd0);
      chk("init_resp_valid", 64'(bus.resp_valid), 64'd0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("init_done", 64'(init_done), 64'd1);
    chk("run_ready", 64'(bus.req_ready), 64'd1);
    chk("run_idle_en", 64'(RW0_en), 64'd0);
    @(posedge clock); #1;
    $display("init sequence done");
  endtask

  localparam logic [WIDTH-1:0] VA = 34'h2_AAAA_5555;
  localparam logic [WIDTH-1:0] VB = 34'h1_0000_0001;
  localparam logic [WIDTH-1:0] VC = 34'h3_0F0F_F0F0;
  localparam logic [WIDTH-1:0] VD = 34'h0_DEAD_BEEF;
  localparam logic [WIDTH-1:0] VE = 34'h1_2345_6789;

  initial begin
    int w;
    logic [WIDTH-1:0] vals [DEPTH];
    vals[0] = VA; vals[1] = VB; vals[2] = VC; vals[3] = VD;

    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wmask  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_outputs", {60'd0, bus.req_ready, bus.resp_valid, init_done, RW0_en}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    init_seq();

    // Freshly zeroed entry.
    send(1'b0, 2'd2, 2'b00, '0, 34'h0, w);
    idle(4);

    // Masked overwrite of the low segment, then latency check of the read.
    send(1'b1, 2'd1, 2'b11, 34'h3_FFFF_FFFF, '0, w);
    send(1'b1, 2'd1, 2'b01, 34'h0, '0, w);
    send(1'b0, 2'd1, 2'b00, '0, 34'h3_FFFE_0000, w);
    idle(0);
    @(negedge clock);
    chk("lat_t1_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("lat_t2_valid", 64'(bus.resp_valid), 64'd1);
    @(posedge clock); #1;
    idle(3);

    // Write with an empty mask is accepted but leaves the entry untouched.
    send(1'b1, 2'd1, 2'b00, 34'h3_FFFF_FFFF, '0, w);
    send(1'b0, 2'd1, 2'b00, '0, 34'h3_FFFE_0000, w);
    idle(4);

    // Full-rate read stream.
    for (int i = 0; i < DEPTH; i++) send(1'b1, ADDR_W'(i), 2'b11, vals[i], '0, w);
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b0, ADDR_W'(i), 2'b00, '0, vals[i], w);
      chk("stream_no_wait", 64'(w), 64'd0);
    end
    idle(0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("stream_valid", 64'(bus.resp_valid), 64'd1);
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("stream_drained", 64'(bus.resp_valid), 64'd0);
    @(posedge clock); #1;

    // Back-pressure: two reads fill the credit, the third waits for the first pop.
    bus.resp_ready = 1'b0;
    send(1'b0, 2'd0, 2'b00, '0, VA, w);
    send(1'b0, 2'd1, 2'b00, '0, VB, w);
    bus.req_addr  = 2'd2;
    bus.req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
      chk("bp_hold_data", 64'(bus.resp_data), 64'(VA));
      @(posedge clock); #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clock);
    chk("bp_ready_on_pop", 64'(bus.req_ready), 64'd1);
    chk("bp_fire_en", 64'(RW0_en), 64'd1);
    if (bus.req_ready) exp_q.push_back(VC);
    @(posedge clock); #1;
    idle(5);

    // Write followed immediately by a read of the same entry.
    send(1'b1, 2'd3, 2'b11, VE, '0, w);
    send(1'b0, 2'd3, 2'b00, '0, VE, w);
    idle(4);

    // Reset with one entry queued and one read in flight.
    bus.resp_ready = 1'b0;
    send(1'b0, 2'd0, 2'b00, '0, VA, w);
    send(1'b0, 2'd3, 2'b00, '0, VE, w);
    idle(0);
    reset_n = 1'b0;
    @(negedge clock);
    chk("pre_rst_valid", 64'(bus.resp_valid), 64'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_q.delete();
    bus.resp_ready = 1'b1;
    init_seq();
    idle(2);
    send(1'b0, 2'd3, 2'b00, '0, 34'h0, w);
    idle(5);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
